// File: rtl/param_seq_detector.sv
// param_seq_detector: programmable serial bit-pattern detector
// with overlap control, input qualifier and saturating match count.
module param_seq_detector #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_1010),
    parameter int DEF_LEN = 4,
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               in,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cfg_overlap,
    output logic               out,
    output logic [CNT_W-1:0]   match_count,
    output logic [LW-1:0]      fill
);

    typedef enum logic {
        FILLING,
        ARMED
    } phase_t;

    localparam logic [LW-1:0] MAXL = LW'(MAX_LEN);

    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] pat;
    logic [MAX_LEN-1:0] hist_n;
    logic [MAX_LEN-1:0] mask;
    logic [LW-1:0]      len;
    logic [LW-1:0]      len_c;
    logic [LW-1:0]      fill_n;
    logic               ovl;
    logic               match;
    phase_t             phase_n;

    always_comb begin
        len_c = cfg_len;
        if (cfg_len == '0) begin
            len_c = LW'(1);
        end else if (cfg_len > MAXL) begin
            len_c = MAXL;
        end
    end

    // len is never 0 once stored, so the shift stays below MAX_LEN
    assign hist_n  = {hist[MAX_LEN-2:0], in};
    assign fill_n  = (fill == MAXL) ? fill : fill + LW'(1);
    assign mask    = {MAX_LEN{1'b1}} >> (MAXL - len);
    assign phase_n = (fill_n >= len) ? ARMED : FILLING;
    assign match   = (phase_n == ARMED)
                  && (((hist_n ^ pat) & mask) == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            hist        <= '0;
            fill        <= '0;
            out         <= 1'b0;
            match_count <= '0;
            pat         <= DEF_PATTERN;
            len         <= LW'(DEF_LEN);
            ovl         <= 1'b1;
        end else if (cfg_load) begin
            hist        <= '0;
            fill        <= '0;
            out         <= 1'b0;
            match_count <= '0;
            pat         <= cfg_pattern;
            len         <= len_c;
            ovl         <= cfg_overlap;
        end else if (in_valid) begin
            hist <= hist_n;
            out  <= match;
            fill <= (match && !ovl) ? '0 : fill_n;
            if (match && match_count != '1) begin
                match_count <= match_count + CNT_W'(1);
            end
        end else begin
            out <= 1'b0;
        end
    end

endmodule

// File: doc/param_seq_detector.md
Name: param_seq_detector

Overview:
Runtime-configurable serial bit-pattern detector. It generalises the fixed 4-bit "1010" detector to a programmable pattern of 1..MAX_LEN bits, with a selectable overlap/non-overlap mode, an input qualifier and a saturating match counter. It sits on a serial data path and gives downstream control logic a single-cycle match strobe.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..32).
CNT_W, 8, width of the saturating match counter.
DEF_PATTERN, 8'b0000_1010, reset-time pattern (MAX_LEN bits, right-aligned).
DEF_LEN, 4, reset-time pattern length.

Ports:
clk  input  1  clock; all logic on the rising edge.
reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
in_valid  input  1  qualifies in; a bit is consumed only when in_valid=1.
in  input  1  serial data bit.
cfg_load  input  1  one-cycle strobe that latches the cfg_* inputs.
cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last.
cfg_len  input  $clog2(MAX_LEN+1)  pattern length.
cfg_overlap  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
out  output  1  match strobe, one cycle wide.
match_count  output  CNT_W  number of matches, saturating.
fill  output  $clog2(MAX_LEN+1)  number of valid history bits.

Behaviour:
- Reset (reset=0 at a rising edge):
  - hist=0, fill=0, out=0, match_count=0.
  - Pattern register = DEF_PATTERN, length register = DEF_LEN, overlap register = 1.
  - Reset has priority over everything else.
- Length clamp: cfg_len=0 is stored as 1; cfg_len>MAX_LEN is stored as MAX_LEN.
- cfg_load=1 (reset=1):
  - Latch pattern/length (with the clamp applied) and overlap.
  - Clear hist, fill, out and match_count.
  - in_valid is ignored in that cycle.
- Shift, on in_valid=1 and cfg_load=0:
  - hist_n = {hist[MAX_LEN-2:0], in}.
  - fill_n = min(fill+1, MAX_LEN).
- Match condition: (hist_n & mask) == (pattern & mask) and fill_n >= length, where mask has the low `length` bits set.
- Registered output:
  - out <= match. It is high in the cycle after the edge that sampled the last pattern bit: 1-edge latency, Moore-style.
  - out=0 in any cycle whose preceding edge did not consume a matching bit. in_valid=0 forces out=0 on the next edge.
- On a match:
  - match_count <= match_count+1, holding at 2^CNT_W-1 (no wrap).
  - overlap=1: hist and fill update normally, so a suffix can seed the next match.
  - overlap=0: fill <= 0, so the next match needs `length` fresh bits.
- in_valid=0: hist, fill and match_count hold.
- Reset mid-stream discards any partial pattern.
- State machine, tracked by fill:
  - FILLING: fill < length, no match possible.
  - ARMED: fill >= length, compare every valid bit.
  - A match in non-overlap mode returns to FILLING.
  - cfg_load returns to FILLING from any state.
- Length-1 patterns match on every equal valid bit (in both modes).

Test Plan:
- Defaults (1010, overlap). After reset, drive in = 1,1,1,0,1,0,1,0,0 one per cycle with in_valid=1 → out pulses after bit 6 and after bit 8 only; match_count=2; fill=8 at end.
- Same stream after cfg_load with cfg_pattern=1010, cfg_len=4, cfg_overlap=0 → out pulses after bit 6 only; match_count=1; fill=0 after bit 6 and 3 at end.
- in_valid gaps: stream 1,0,1,0 with in_valid=0 cycles (in toggling) between each bit → one out pulse, after the cycle carrying the 4th valid bit; gap cycles change nothing.
- Saturation: CNT_W=2, cfg_len=1, cfg_pattern=1, six valid 1s → out high for 6 consecutive cycles; match_count 1,2,3,3,3,3.
- Clamp and length extremes: cfg_len=0 → behaves as length 1. cfg_len=15 with MAX_LEN=8 → length 8; pattern 8'hA5 matches only after 8 valid bits; a 7-bit-prefix stream gives no match.
- Reset and reconfig mid-stream: feed 1,0,1, then reset=0 for one edge, then 0 → no match, fill=1, pattern back to 1010. Repeat with cfg_load in place of reset → counters cleared, new pattern active.
